mdp3_order_book: RTL

- Consumes decoded incremental-refresh entries from the MDP3 parser stage and maintains a price-sorted book for one instrument: up to DEPTH bid and DEPTH ask levels.
- Publishes top-of-book and a registered random-access level read port to the downstream strategy/display logic.
- Multi-cycle update FSM with a busy indication; messages arriving while busy are dropped and flagged.

---
 rtl/mdp3_order_book_if.sv | 55 +++++
 rtl/mdp3_order_book.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdp3_order_book_if.sv
// mdp3_order_book_if: parser entry inputs, book outputs and level read port
// for the single-instrument MDP3 order book.
interface mdp3_order_book_if;
    logic        message_ready;
    logic        enable_order_book;
    logic [1:0]  ACTION;
    logic [1:0]  ENTRY_TYPE;
    logic [31:0] SECURITY_ID;
    logic [63:0] PRICE;
    logic [15:0] QUANTITY;
    logic [7:0]  NUM_ORDERS;

    logic        book_busy;
    logic        book_updated;
    logic        best_bid_valid;
    logic        best_ask_valid;
    logic [63:0] best_bid_price;
    logic [63:0] best_ask_price;
    logic [15:0] best_bid_qty;
    logic [15:0] best_ask_qty;

    logic        rd_side;
    logic [2:0]  rd_level;
    logic        rd_valid;
    logic [63:0] rd_price;
    logic [15:0] rd_qty;
    logic [7:0]  rd_orders;

    logic        miss_err;
    logic        overflow_err;

    modport master (
        output message_ready, enable_order_book, ACTION, ENTRY_TYPE,
        output SECURITY_ID, PRICE, QUANTITY, NUM_ORDERS,
        output rd_side, rd_level,
        input  book_busy, book_updated,
        input  best_bid_valid, best_ask_valid,
        input  best_bid_price, best_ask_price,
        input  best_bid_qty, best_ask_qty,
        input  rd_valid, rd_price, rd_qty, rd_orders,
        input  miss_err, overflow_err
    );

    modport slave (
        input  message_ready, enable_order_book, ACTION, ENTRY_TYPE,
        input  SECURITY_ID, PRICE, QUANTITY, NUM_ORDERS,
        input  rd_side, rd_level,
        output book_busy, book_updated,
        output best_bid_valid, best_ask_valid,
        output best_bid_price, best_ask_price,
        output best_bid_qty, best_ask_qty,
        output rd_valid, rd_price, rd_qty, rd_orders,
        output miss_err, overflow_err
    );
endinterface

// File: rtl/mdp3_order_book.sv
// mdp3_order_book: price-sorted bid/ask book for one instrument, fed by
// MDP3 incremental-refresh entries through a capture/search/apply FSM.
module mdp3_order_book #(
    parameter int          DEPTH  = 4,
    parameter logic [31:0] SEC_ID = 32'h0000_0000
) (
    input logic              clk,
    input logic              reset,
    mdp3_order_book_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_APPLY  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   mr_q, mr_d;

    logic [1:0]  act_q, act_d;
    logic        side_q, side_d;
    logic [63:0] px_q, px_d;
    logic [15:0] qty_q, qty_d;
    logic [7:0]  ord_q, ord_d;

    logic [DEPTH-1:0] match_q, match_d;
    logic [DEPTH-1:0] better_q, better_d;

    logic        vld_q [2][DEPTH];
    logic        vld_d [2][DEPTH];
    logic [63:0] prc_q [2][DEPTH];
    logic [63:0] prc_d [2][DEPTH];
    logic [15:0] lq_q  [2][DEPTH];
    logic [15:0] lq_d  [2][DEPTH];
    logic [7:0]  lo_q  [2][DEPTH];
    logic [7:0]  lo_d  [2][DEPTH];

    logic upd_q, upd_d;
    logic miss_q, miss_d;
    logic ovf_q, ovf_d;
    logic apply_miss;

    logic        bbv_q, bbv_d, bav_q, bav_d;
    logic [63:0] bbp_q, bbp_d, bap_q, bap_d;
    logic [15:0] bbq_q, bbq_d, baq_q, baq_d;

    logic        rdv_q, rdv_d;
    logic [63:0] rdp_q, rdp_d;
    logic [15:0] rdq_q, rdq_d;
    logic [7:0]  rdo_q, rdo_d;
    int          rd_idx;

    logic cap;
    logic accept;

    assign cap    = bus.message_ready && !mr_q && bus.enable_order_book;
    assign accept = (bus.SECURITY_ID == SEC_ID) && (bus.ACTION != 2'd3)
                    && !bus.ENTRY_TYPE[1];

    // FSM sequencing, entry latch, pulse and sticky error generation
    always_comb begin
        state_d = state_q;
        mr_d    = bus.message_ready;
        act_d   = act_q;
        side_d  = side_q;
        px_d    = px_q;
        qty_d   = qty_q;
        ord_d   = ord_q;
        upd_d   = 1'b0;
        miss_d  = 1'b0;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (cap && accept) begin
                    act_d   = bus.ACTION;
                    side_d  = bus.ENTRY_TYPE[0];
                    px_d    = bus.PRICE;
                    qty_d   = bus.QUANTITY;
                    ord_d   = bus.NUM_ORDERS;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: state_d = S_APPLY;
            S_APPLY: begin
                state_d = S_IDLE;
                upd_d   = 1'b1;
                miss_d  = apply_miss;
            end
            default: state_d = S_IDLE;
        endcase
        if (cap && state_q != S_IDLE) begin
            ovf_d = 1'b1;
        end
    end

    // Parallel price compare against every level of the selected side
    always_comb begin
        match_d  = match_q;
        better_d = better_q;
        if (state_q == S_SEARCH) begin
            for (int i = 0; i < DEPTH; i++) begin
                match_d[i] = vld_q[side_q][i] && (prc_q[side_q][i] == px_q);
                if (!vld_q[side_q][i]) begin
                    better_d[i] = 1'b1;
                end else if (side_q) begin
                    better_d[i] = $signed(px_q) < $signed(prc_q[side_q][i]);
                end else begin
                    better_d[i] = $signed(px_q) > $signed(prc_q[side_q][i]);
                end
            end
        end
    end

    // Book modification: overwrite, insert with shift-down, delete with shift-up
    always_comb begin
        int  mi;
        int  bi;
        logic mf;
        logic bf;
        vld_d      = vld_q;
        prc_d      = prc_q;
        lq_d       = lq_q;
        lo_d       = lo_q;
        apply_miss = 1'b0;
        mi = 0;
        bi = 0;
        mf = 1'b0;
        bf = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                mf = 1'b1;
                mi = i;
            end
            if (better_q[i]) begin
                bf = 1'b1;
                bi = i;
            end
        end
        if (state_q == S_APPLY) begin
            unique case (act_q)
                2'd0: begin
                    if (mf) begin
                        lq_d[side_q][mi] = qty_q;
                        lo_d[side_q][mi] = ord_q;
                    end else if (bf) begin
                        for (int i = 1; i < DEPTH; i++) begin
                            if (i > bi) begin
                                vld_d[side_q][i] = vld_q[side_q][i-1];
                                prc_d[side_q][i] = prc_q[side_q][i-1];
                                lq_d[side_q][i]  = lq_q[side_q][i-1];
                                lo_d[side_q][i]  = lo_q[side_q][i-1];
                            end
                        end
                        vld_d[side_q][bi] = 1'b1;
                        prc_d[side_q][bi] = px_q;
                        lq_d[side_q][bi]  = qty_q;
                        lo_d[side_q][bi]  = ord_q;
                    end
                end
                2'd1: begin
                    if (mf) begin
                        lq_d[side_q][mi] = qty_q;
                        lo_d[side_q][mi] = ord_q;
                    end else begin
                        apply_miss = 1'b1;
                    end
                end
                2'd2: begin
                    if (mf) begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            if (i >= mi) begin
                                vld_d[side_q][i] = vld_q[side_q][i+1];
                                prc_d[side_q][i] = prc_q[side_q][i+1];
                                lq_d[side_q][i]  = lq_q[side_q][i+1];
                                lo_d[side_q][i]  = lo_q[side_q][i+1];
                            end
                        end
                        vld_d[side_q][DEPTH-1] = 1'b0;
                    end else begin
                        apply_miss = 1'b1;
                    end
                end
                default: apply_miss = 1'b0;
            endcase
        end
    end

    // Top-of-book taken from the post-update book so it lines up with book_updated
    always_comb begin
        bbv_d = vld_d[0][0];
        bav_d = vld_d[1][0];
        bbp_d = vld_d[0][0] ? prc_d[0][0] : 64'd0;
        bap_d = vld_d[1][0] ? prc_d[1][0] : 64'd0;
        bbq_d = vld_d[0][0] ? lq_d[0][0] : 16'd0;
        baq_d = vld_d[1][0] ? lq_d[1][0] : 16'd0;
    end

    // Random-access level read from the current (pre-update) book
    always_comb begin
        rd_idx = int'(bus.rd_level);
        rdv_d  = 1'b0;
        rdp_d  = 64'd0;
        rdq_d  = 16'd0;
        rdo_d  = 8'd0;
        if (rd_idx < DEPTH) begin
            rdv_d = vld_q[bus.rd_side][rd_idx];
            rdp_d = prc_q[bus.rd_side][rd_idx];
            rdq_d = lq_q[bus.rd_side][rd_idx];
            rdo_d = lo_q[bus.rd_side][rd_idx];
        end
    end

    // Control and latched-entry registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mr_q     <= 1'b0;
            act_q    <= 2'd0;
            side_q   <= 1'b0;
            px_q     <= 64'd0;
            qty_q    <= 16'd0;
            ord_q    <= 8'd0;
            match_q  <= '0;
            better_q <= '0;
            upd_q    <= 1'b0;
            miss_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mr_q     <= mr_d;
            act_q    <= act_d;
            side_q   <= side_d;
            px_q     <= px_d;
            qty_q    <= qty_d;
            ord_q    <= ord_d;
            match_q  <= match_d;
            better_q <= better_d;
            upd_q    <= upd_d;
            miss_q   <= miss_d;
            ovf_q    <= ovf_d;
        end
    end

    // Level storage for both sides
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    vld_q[s][i] <= 1'b0;
                    prc_q[s][i] <= 64'd0;
                    lq_q[s][i]  <= 16'd0;
                    lo_q[s][i]  <= 8'd0;
                end
            end
        end else begin
            vld_q <= vld_d;
            prc_q <= prc_d;
            lq_q  <= lq_d;
            lo_q  <= lo_d;
        end
    end

    // Registered best-of-book and read-port outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bbv_q <= 1'b0;
            bav_q <= 1'b0;
            bbp_q <= 64'd0;
            bap_q <= 64'd0;
            bbq_q <= 16'd0;
            baq_q <= 16'd0;
            rdv_q <= 1'b0;
            rdp_q <= 64'd0;
            rdq_q <= 16'd0;
            rdo_q <= 8'd0;
        end else begin
            bbv_q <= bbv_d;
            bav_q <= bav_d;
            bbp_q <= bbp_d;
            bap_q <= bap_d;
            bbq_q <= bbq_d;
            baq_q <= baq_d;
            rdv_q <= rdv_d;
            rdp_q <= rdp_d;
            rdq_q <= rdq_d;
            rdo_q <= rdo_d;
        end
    end

    assign bus.book_busy      = (state_q != S_IDLE);
    assign bus.book_updated   = upd_q;
    assign bus.miss_err       = miss_q;
    assign bus.overflow_err   = ovf_q;
    assign bus.best_bid_valid = bbv_q;
    assign bus.best_ask_valid = bav_q;
    assign bus.best_bid_price = bbp_q;
    assign bus.best_ask_price = bap_q;
    assign bus.best_bid_qty   = bbq_q;
    assign bus.best_ask_qty   = baq_q;
    assign bus.rd_valid       = rdv_q;
    assign bus.rd_price       = rdp_q;
    assign bus.rd_qty         = rdq_q;
    assign bus.rd_orders      = rdo_q;

endmodule
